fifo_access_sched: RTL and testbench
====================================

// Module: fifo_access_sched
// PURPOSE
//  Sequences all enqueue/dequeue traffic to the 8x4 FIFO (register file + list control unit).
//  Shares the FIFO write side between two producers, round-robin, and serves one consumer.
//  Issues at most one single-cycle enq or deq pulse per transaction, then waits for full/empty to settle.
//  Sits between the producers/consumer and the FIFO control unit; replaces button edge detectors on that path.
// PARAMETERS
//  DATA_W      4  width of FIFO data and producer/consumer data
//  SETTLE_CYC  1  cycles waited after each enq/deq pulse before full/empty are trusted (1..15)
// PORTS
//  clk       in   1       system clock; all state on rising edge
//  rst       in   1       asynchronous, active-low reset
//  req       in   2       producer push requests; req[i] held with din_i stable until gnt[i]
//  din0      in   DATA_W  producer 0 data
//  din1      in   DATA_W  producer 1 data
//  gnt       out  2       one-hot, 1-cycle push acknowledge
//  pop_req   in   1       consumer pop request, held until pop_ack
//  pop_ack   out  1       1-cycle pulse; pop_data valid in the same cycle
//  pop_data  out  DATA_W  registered dequeued word; holds last value until next pop
//  enq       out  1       1-cycle enqueue pulse to FIFO control
//  fifo_in   out  DATA_W  enqueue data, valid while enq=1
//  deq       out  1       1-cycle dequeue pulse to FIFO control
//  fifo_out  in   DATA_W  FIFO head word (updated by FIFO after deq)
//  full      in   1       FIFO full flag
//  empty     in   1       FIFO empty flag
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, gnt=0, pop_ack=0, enq=0, deq=0, fifo_in=0, pop_data=0,
//    rr_last=1 (producer 0 wins first), op_turn=PUSH, settle counter=0. Mid-transaction reset aborts
//    silently; no gnt/pop_ack is issued for the aborted op.
//  - FSM: IDLE -> ISSUE -> SETTLE -> DONE -> IDLE. Each transaction is exactly 3+SETTLE_CYC cycles.
//  - IDLE: push_ok = |req & !full; pop_ok = pop_req & !empty.
//    both ok: op = op_turn, op_turn toggles; one ok: that op, op_turn unchanged; none: stay IDLE.
//    Push requester chosen round-robin: if both req, pick the one != rr_last; else the single one.
//    Chosen op/index/data latched on the IDLE->ISSUE edge.
//  - ISSUE (1 cycle): push: enq=1, fifo_in=latched din, gnt[idx]=1, rr_last<=idx.
//    pop: deq=1. Never enq and deq in the same cycle.
//  - SETTLE: counter counts SETTLE_CYC cycles, all strobes low.
//  - DONE (1 cycle): pop: pop_data<=fifo_out, pop_ack=1 one cycle later aligned with new pop_data
//    (pop_ack and pop_data change on same edge). Push: no strobe. Then IDLE.
//  - full: pushes stall (no gnt) until a pop frees a slot; req may stay high indefinitely.
//  - empty: pop_req stalls (no pop_ack); pushes proceed.
//  - Requests dropped while in flight (req deasserted before gnt) are not a protocol violation only
//    in IDLE; deassert after latch still completes the latched push.
//  - full/empty sampled only in IDLE; no wrap-around arithmetic here (FIFO owns pointers).
// STRUCTURE
//  - Shared package fifo_pkg: DATA_W constant, state enum {IDLE,ISSUE,SETTLE,DONE},
//    op encoding {OP_PUSH,OP_POP}.
//  - Sub-module rr_arb2: 2-way round-robin picker (req[1:0], last -> one-hot grant, index).
//  - Settle counter 4 bits; all outputs registered.
// TESTING
//  1 Reset: rst=0 mid-ISSUE -> enq=deq=gnt=pop_ack=0 immediately; after release state IDLE.
//  2 Single push: req=01, din0=4'hA, empty FIFO -> enq pulse with fifo_in=A 2nd cycle, gnt=01 same
//    cycle; next op starts after 3+SETTLE_CYC cycles.
//  3 Round-robin: req=11 held, din0=1, din1=2 for 4 pushes -> fifo_in sequence 1,2,1,2; gnt alternates.
//  4 Full stall: 8 pushes then req=01 -> no enq/gnt; one pop_req -> pop_data=first word, then push proceeds.
//  5 Alternation: req=01 and pop_req=1 with FIFO holding 3 words -> ops push,pop,push,pop strictly.
//  6 Empty pop: pop_req=1, empty=1 for 20 cycles -> no deq, no pop_ack; push of 4'h5 then pop_ack
//    with pop_data=5.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and constants for the FIFO access scheduler
// Purpose: default data width, scheduler state encoding and operation encoding.
// Ports: none (package).
package fifo_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_t;

endpackage

// File: rtl/fifo_access_sched_if.sv
// rtl/fifo_access_sched_if.sv - producer/consumer and FIFO-control signal bundle
// Purpose: groups every handshake and data signal around the scheduler.
// Ports (signals):
//   req[1:0], din0, din1, gnt[1:0]  producer push handshake
//   pop_req, pop_ack, pop_data      consumer pop handshake
//   enq, fifo_in, deq               strobes/data to FIFO control
//   fifo_out, full, empty           head word and status from FIFO control
// Modports: slave = scheduler view, master = environment view.
interface fifo_access_sched_if #(
  parameter int DATA_W = fifo_pkg::DATA_W
);

  logic [1:0]        req;
  logic [DATA_W-1:0] din0;
  logic [DATA_W-1:0] din1;
  logic [1:0]        gnt;
  logic              pop_req;
  logic              pop_ack;
  logic [DATA_W-1:0] pop_data;
  logic              enq;
  logic [DATA_W-1:0] fifo_in;
  logic              deq;
  logic [DATA_W-1:0] fifo_out;
  logic              full;
  logic              empty;

  modport slave (
    input  req, din0, din1, pop_req, fifo_out, full, empty,
    output gnt, pop_ack, pop_data, enq, fifo_in, deq
  );

  modport master (
    output req, din0, din1, pop_req, fifo_out, full, empty,
    input  gnt, pop_ack, pop_data, enq, fifo_in, deq
  );

endinterface

// File: rtl/fifo_access_sched_rr_arb2.sv
// rtl/fifo_access_sched_rr_arb2.sv - two-way round-robin picker
// Purpose: picks one of two push requesters, favouring the one not served last.
// Ports:
//   req[1:0]  in   request vector
//   last      in   index of the requester served most recently
//   gnt[1:0]  out  one-hot pick (zero when no request)
//   idx       out  index of the pick
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       idx
);

  always_comb begin
    gnt = 2'b00;
    idx = 1'b0;
    case (req)
      2'b01: begin
        gnt = 2'b01;
        idx = 1'b0;
      end
      2'b10: begin
        gnt = 2'b10;
        idx = 1'b1;
      end
      2'b11: begin
        idx = ~last;
        gnt = last ? 2'b01 : 2'b10;
      end
      default: begin
        gnt = 2'b00;
        idx = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fifo_access_sched.sv
// rtl/fifo_access_sched.sv - sequences enqueue/dequeue traffic to the 8x4 FIFO
// Purpose: shares the FIFO write side between two producers (round-robin),
//   serves one consumer, issues one enq/deq pulse per transaction and waits
//   SETTLE_CYC cycles for full/empty to settle. All outputs are registered.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-low reset
//   bus   slave modport of fifo_access_sched_if (producer, consumer, FIFO side)
module fifo_access_sched #(
  parameter int DATA_W     = fifo_pkg::DATA_W,
  parameter int SETTLE_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_access_sched_if.slave   bus
);

  import fifo_pkg::*;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  op_t               op_turn_q, op_turn_d;
  logic              idx_q, idx_d;
  logic              rr_last_q, rr_last_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              enq_q, enq_d;
  logic              deq_q, deq_d;
  logic              pop_ack_q, pop_ack_d;
  logic [DATA_W-1:0] fifo_in_q, fifo_in_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;

  logic              push_ok, pop_ok, do_push, do_pop;
  logic [1:0]        arb_gnt;
  logic              arb_idx;

  rr_arb2 u_arb (
    .req  (bus.req),
    .last (rr_last_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  // When both sides are ready, op_turn decides; a lone ready side always wins.
  assign push_ok = (|bus.req) & ~bus.full;
  assign pop_ok  = bus.pop_req & ~bus.empty;
  assign do_push = push_ok & (~pop_ok | (op_turn_q == OP_PUSH));
  assign do_pop  = pop_ok & ~do_push;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    op_turn_d  = op_turn_q;
    idx_d      = idx_q;
    rr_last_d  = rr_last_q;
    cnt_d      = cnt_q;
    gnt_d      = 2'b00;
    enq_d      = 1'b0;
    deq_d      = 1'b0;
    pop_ack_d  = 1'b0;
    fifo_in_d  = fifo_in_q;
    pop_data_d = pop_data_q;

    case (state_q)
      IDLE: begin
        if (push_ok && pop_ok) begin
          op_turn_d = (op_turn_q == OP_PUSH) ? OP_POP : OP_PUSH;
        end
        // Strobes are loaded here so they appear registered during ISSUE.
        if (do_push) begin
          state_d   = ISSUE;
          op_d      = OP_PUSH;
          idx_d     = arb_idx;
          fifo_in_d = arb_idx ? bus.din1 : bus.din0;
          gnt_d     = arb_gnt;
          enq_d     = 1'b1;
        end else if (do_pop) begin
          state_d = ISSUE;
          op_d    = OP_POP;
          deq_d   = 1'b1;
        end
      end
      ISSUE: begin
        state_d = SETTLE;
        cnt_d   = 4'd0;
        if (op_q == OP_PUSH) begin
          rr_last_d = idx_q;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        // fifo_out already reflects the dequeued word; capture it with the ack.
        if (op_q == OP_POP) begin
          pop_data_d = bus.fifo_out;
          pop_ack_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= OP_PUSH;
      op_turn_q  <= OP_PUSH;
      idx_q      <= 1'b0;
      rr_last_q  <= 1'b1;
      cnt_q      <= 4'd0;
      gnt_q      <= 2'b00;
      enq_q      <= 1'b0;
      deq_q      <= 1'b0;
      pop_ack_q  <= 1'b0;
      fifo_in_q  <= '0;
      pop_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      op_turn_q  <= op_turn_d;
      idx_q      <= idx_d;
      rr_last_q  <= rr_last_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      enq_q      <= enq_d;
      deq_q      <= deq_d;
      pop_ack_q  <= pop_ack_d;
      fifo_in_q  <= fifo_in_d;
      pop_data_q <= pop_data_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.enq      = enq_q;
  assign bus.deq      = deq_q;
  assign bus.pop_ack  = pop_ack_q;
  assign bus.fifo_in  = fifo_in_q;
  assign bus.pop_data = pop_data_q;

endmodule

// File: tb/tb_fifo_access_sched.sv
// tb/tb_fifo_access_sched.sv - directed self-checking bench for fifo_access_sched
module tb_fifo_access_sched;

  import fifo_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  fifo_access_sched_if #(.DATA_W(4)) bus ();

  fifo_access_sched #(.DATA_W(4), .SETTLE_CYC(1)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  // 8x4 FIFO model: head register loads the dequeued word on deq.
  logic [3:0] mem [8];
  logic [2:0] wp, rp;
  logic [3:0] cnt;
  logic [3:0] head;

  always_ff @(posedge clk) begin
    if (bus.enq) mem[wp] <= bus.fifo_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0; rp <= '0; cnt <= '0; head <= '0;
    end else begin
      if (bus.enq) wp <= wp + 3'd1;
      if (bus.deq) begin
        head <= mem[rp];
        rp   <= rp + 3'd1;
      end
      if (bus.enq && !bus.deq) cnt <= cnt + 4'd1;
      else if (bus.deq && !bus.enq) cnt <= cnt - 4'd1;
    end
  end

  assign bus.full     = (cnt == 4'd8);
  assign bus.empty    = (cnt == 4'd0);
  assign bus.fifo_out = head;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // which: 0 enq, 1 deq, 2 enq|deq, 3 pop_ack
  task automatic wait_chk(input string tag, input int which, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      step();
      case (which)
        0:       hit = bus.enq;
        1:       hit = bus.deq;
        2:       hit = bus.enq | bus.deq;
        default: hit = bus.pop_ack;
      endcase
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = 2'b00; bus.pop_req = 1'b0;
    bus.din0 = 4'h0; bus.din1 = 4'h0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_a, seen_b;

    // Reset state
    do_reset();
    chk("rst_enq", 32'(bus.enq), 32'd0);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_fifo_in", 32'(bus.fifo_in), 32'd0);
    chk("rst_pop_data", 32'(bus.pop_data), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));

    // 1: reset asserted in the middle of ISSUE
    bus.req = 2'b01; bus.din0 = 4'h3;
    step();
    chk("t1_enq_issue", 32'(bus.enq), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_enq", 32'(bus.enq), 32'd0);
    chk("t1_deq", 32'(bus.deq), 32'd0);
    chk("t1_gnt", 32'(bus.gnt), 32'd0);
    chk("t1_pop_ack", 32'(bus.pop_ack), 32'd0);
    chk("t1_fifo_in", 32'(bus.fifo_in), 32'd0);
    bus.req = 2'b00;
    step();
    rst_n = 1'b1;
    step();
    chk("t1_state_idle", 32'(dut.state_q), 32'(IDLE));
    chk("t1_no_enq", 32'(bus.enq), 32'd0);

    // 2: single push, then back-to-back push spacing of 4 cycles
    do_reset();
    bus.req = 2'b01; bus.din0 = 4'hA;
    step();
    chk("t2_enq", 32'(bus.enq), 32'd1);
    chk("t2_fifo_in", 32'(bus.fifo_in), 32'hA);
    chk("t2_gnt", 32'(bus.gnt), 32'b01);
    bus.din0 = 4'hB;
    seen_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.enq || bus.gnt != 2'b00) seen_a = 1'b1;
    end
    chk("t2_gap_quiet", 32'(seen_a), 32'd0);
    step();
    chk("t2_enq2", 32'(bus.enq), 32'd1);
    chk("t2_fifo_in2", 32'(bus.fifo_in), 32'hB);
    bus.req = 2'b00;

    // 3: round-robin with both producers held
    do_reset();
    bus.req = 2'b11; bus.din0 = 4'h1; bus.din1 = 4'h2;
    wait_chk("t3_push0_seen", 0, 8);
    chk("t3_data0", 32'(bus.fifo_in), 32'h1);
    chk("t3_gnt0", 32'(bus.gnt), 32'b01);
    wait_chk("t3_push1_seen", 0, 8);
    chk("t3_data1", 32'(bus.fifo_in), 32'h2);
    chk("t3_gnt1", 32'(bus.gnt), 32'b10);
    wait_chk("t3_push2_seen", 0, 8);
    chk("t3_data2", 32'(bus.fifo_in), 32'h1);
    chk("t3_gnt2", 32'(bus.gnt), 32'b01);
    wait_chk("t3_push3_seen", 0, 8);
    chk("t3_data3", 32'(bus.fifo_in), 32'h2);
    chk("t3_gnt3", 32'(bus.gnt), 32'b10);
    bus.req = 2'b00;

    // 4: fill the FIFO, stall while full, one pop releases a slot
    do_reset();
    bus.req = 2'b01; bus.din0 = 4'h3;
    for (int i = 0; i < 8; i++) begin
      wait_chk("t4_fill_seen", 0, 8);
      bus.din0 = bus.din0 + 4'h1;
    end
    bus.din0 = 4'hF;
    seen_a = 1'b0;
    seen_b = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.enq) seen_a = 1'b1;
      if (bus.gnt != 2'b00) seen_b = 1'b1;
    end
    chk("t4_full_no_enq", 32'(seen_a), 32'd0);
    chk("t4_full_no_gnt", 32'(seen_b), 32'd0);
    bus.pop_req = 1'b1;
    wait_chk("t4_deq_seen", 1, 4);
    wait_chk("t4_ack_seen", 3, 8);
    chk("t4_pop_data", 32'(bus.pop_data), 32'h3);
    bus.pop_req = 1'b0;
    wait_chk("t4_push_after_pop", 0, 6);
    chk("t4_push_data", 32'(bus.fifo_in), 32'hF);
    chk("t4_push_gnt", 32'(bus.gnt), 32'b01);
    bus.req = 2'b00;

    // 5: strict push/pop alternation with 3 words stored
    do_reset();
    bus.req = 2'b01; bus.din0 = 4'h1;
    wait_chk("t5_pre0", 0, 8);
    bus.din0 = 4'h2;
    wait_chk("t5_pre1", 0, 8);
    bus.din0 = 4'h3;
    wait_chk("t5_pre2", 0, 8);
    bus.din0 = 4'h4;
    bus.pop_req = 1'b1;
    wait_chk("t5_op0_seen", 2, 8);
    chk("t5_op0_push", 32'(bus.enq), 32'd1);
    chk("t5_op0_data", 32'(bus.fifo_in), 32'h4);
    bus.din0 = 4'h5;
    wait_chk("t5_op1_seen", 2, 8);
    chk("t5_op1_pop", 32'(bus.deq), 32'd1);
    wait_chk("t5_op1_ack", 3, 8);
    chk("t5_op1_data", 32'(bus.pop_data), 32'h1);
    wait_chk("t5_op2_seen", 2, 8);
    chk("t5_op2_push", 32'(bus.enq), 32'd1);
    chk("t5_op2_data", 32'(bus.fifo_in), 32'h5);
    bus.din0 = 4'h6;
    wait_chk("t5_op3_seen", 2, 8);
    chk("t5_op3_pop", 32'(bus.deq), 32'd1);
    wait_chk("t5_op3_ack", 3, 8);
    chk("t5_op3_data", 32'(bus.pop_data), 32'h2);
    bus.req = 2'b00;
    bus.pop_req = 1'b0;

    // 6: pop on empty stalls, a push then lets it complete
    do_reset();
    bus.pop_req = 1'b1;
    seen_a = 1'b0;
    seen_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.deq) seen_a = 1'b1;
      if (bus.pop_ack) seen_b = 1'b1;
    end
    chk("t6_empty_no_deq", 32'(seen_a), 32'd0);
    chk("t6_empty_no_ack", 32'(seen_b), 32'd0);
    bus.req = 2'b01; bus.din0 = 4'h5;
    wait_chk("t6_push_seen", 0, 4);
    chk("t6_push_data", 32'(bus.fifo_in), 32'h5);
    bus.req = 2'b00;
    wait_chk("t6_deq_seen", 1, 8);
    wait_chk("t6_ack_seen", 3, 8);
    chk("t6_pop_data", 32'(bus.pop_data), 32'h5);
    bus.pop_req = 1'b0;
    step();
    chk("t6_ack_one_cycle", 32'(bus.pop_ack), 32'd0);
    chk("t6_pop_data_hold", 32'(bus.pop_data), 32'h5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
